lz77_decoder: RTL and testbench
===============================

Name: lz77_decoder

Overview:
- Consumes the (offset, match_len, char_nxt) token stream produced by the team's LZ77 encoder and rebuilds the original character stream.
- Output rate is one character per clock.
- Holds a 9-entry history (search) buffer. Match characters are copied out of this buffer, then the token's literal is emitted.
- Sits downstream of the encoder, or of a token FIFO, in the HW3 compression/decompression loop.

Parameters:
SEARCH_DEPTH, 9, history entries; legal offsets are 0..SEARCH_DEPTH-1
TERM_CHAR, 8'h24, terminating character ('$'); decoding ends after it is emitted

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
code_valid  input  1  token present on offset/match_len/char_nxt
code_ready  output  1  decoder accepts a token this cycle
offset  input  4  history index; 0 = most recently emitted char
match_len  input  3  number of chars to copy (0..7)
char_nxt  input  8  literal emitted after the copied chars
out_valid  output  1  out_char holds a decoded char this cycle
out_char  output  8  decoded character
finish  output  1  TERM_CHAR has been emitted; sticky until reset
err  output  1  illegal offset seen; sticky until reset

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; out_valid=0, out_char=8'h00, finish=0, err=0.
  - History entries hist[0..8]=8'h00; emitted-count hist_cnt=0.
- Handshake:
  - A token transfers on a rising edge with code_valid && code_ready.
  - Token fields are latched at that edge.
  - The upstream must hold the token fields stable while code_valid=1 and code_ready=0.
- code_ready is combinational from state and latched literal:
  - 1 in IDLE.
  - 1 in LIT unless the latched char_nxt==TERM_CHAR.
  - 0 in COPY and DONE.
- States:
  - IDLE: wait for a token. On accept, go to COPY if match_len>0, else LIT. Load len_cnt=match_len.
  - COPY: each edge registers out_char<=hist[offset], out_valid<=1, shifts that char into hist[0] (hist[k+1]<=hist[k]) and decrements len_cnt. Go to LIT when len_cnt reaches 1.
  - LIT: the edge registers out_char<=char_nxt, out_valid<=1 and shifts it into history.
    - If char_nxt==TERM_CHAR: go to DONE.
    - Else if a new token is accepted on the same edge: go to COPY or LIT as from IDLE (back-to-back, no bubble).
    - Else: go to IDLE.
  - DONE: out_valid<=0 from the next edge. finish<=1 on the edge after '$' is registered, i.e. finish rises one cycle after out_valid/out_char='$'. Remains in DONE until reset.
- Overlapping copies:
  - offset is held constant while history shifts, so offset < match_len repeats the pattern.
  - Example: history "a", token (0,3,'b') -> a a a b.
- Latency: the first char of a token appears on out_valid one cycle after its accept edge. A token takes match_len+1 output cycles.
- out_valid=0 in any cycle where no char was registered on the preceding edge (IDLE gap).
- hist_cnt increments per emitted char and saturates at SEARCH_DEPTH.
- Illegal offset: match_len>0 and (offset>=SEARCH_DEPTH or offset>=hist_cnt).
  - err<=1, sticky.
  - The match portion is skipped (treated as match_len=0) and only the literal is emitted.
- Reset mid-token: all state is discarded immediately; no partial output after reset deasserts.

Decomposition:
- Shared package lz77_pkg: SEARCH_DEPTH, LOOK_DEPTH=8, OFF_W=4, LEN_W=3, CHAR_W=8, TERM_CHAR, and the decoder state enum {IDLE, COPY, LIT, DONE}. The encoder uses the same constants.
- One natural sub-module: lz77_hist_buf, a SEARCH_DEPTH x 8 shift register with a single read port by index, shift-in enable, and async reset.

Test Plan:
- Reset, then tokens (0,0,'a'), (0,3,'b') back-to-back -> out_char a,a,a,a,b on 5 consecutive cycles; code_ready=0 during the 3 COPY cycles.
- History "abc" (from 3 literal tokens), token (2,6,'x') -> a,b,c,a,b,c,x; offset stays 2 throughout.
- Token (0,0,'$') after "ab" -> '$' with out_valid=1; next cycle finish=1, out_valid=0, code_ready=0; further code_valid ignored for 10 cycles.
- After only 2 chars emitted, token (5,2,'z') -> err=1, single output 'z', 2-cycle skip absent; err stays 1 on subsequent legal tokens.
- code_valid toggling every other cycle on literal tokens -> one out_valid pulse per token, out_valid=0 during gaps, no lost or duplicated chars.
- Reset asserted in the middle of a (1,7,'q') copy -> out_valid=0 and all outputs at reset values immediately; after release, token (0,0,'k') yields 'k' with err=0.

Source files
------------

// File: rtl/lz77_pkg.sv
// Shared LZ77 constants and decoder state type, common to the encoder and decoder.
// Offsets index history with 0 as the most recently emitted character.
package lz77_pkg;

    localparam int unsigned SEARCH_DEPTH = 9;
    localparam int unsigned LOOK_DEPTH   = 8;
    localparam int unsigned OFF_W        = 4;
    localparam int unsigned LEN_W        = 3;
    localparam int unsigned CHAR_W       = 8;
    localparam int unsigned CNT_W        = 4;

    localparam logic [CHAR_W-1:0] TERM_CHAR = 8'h24;

    typedef enum logic [1:0] {
        IDLE,
        COPY,
        LIT,
        DONE
    } dec_state_e;

endpackage

// File: rtl/lz77_decoder_if.sv
// Token-in / character-out bus of the LZ77 decoder.
// The master drives tokens; the slave (decoder) returns decoded characters and status.
interface lz77_decoder_if;
    import lz77_pkg::*;

    logic              code_valid;
    logic              code_ready;
    logic [OFF_W-1:0]  offset;
    logic [LEN_W-1:0]  match_len;
    logic [CHAR_W-1:0] char_nxt;
    logic              out_valid;
    logic [CHAR_W-1:0] out_char;
    logic              finish;
    logic              err;

    modport master (
        output code_valid, offset, match_len, char_nxt,
        input  code_ready, out_valid, out_char, finish, err
    );

    modport slave (
        input  code_valid, offset, match_len, char_nxt,
        output code_ready, out_valid, out_char, finish, err
    );

endinterface

// File: rtl/lz77_hist_buf.sv
// History shift register: new characters enter at entry 0, older ones move up.
// Single combinational read port indexed by offset; out-of-range reads return zero.
module lz77_hist_buf
    import lz77_pkg::*;
#(
    parameter int unsigned DEPTH = SEARCH_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_shift_en,
    input  logic [CHAR_W-1:0] i_shift_char,
    input  logic [OFF_W-1:0]  i_rd_idx,
    output logic [CHAR_W-1:0] o_rd_char
);

    logic [CHAR_W-1:0] r_hist [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                r_hist[k] <= '0;
            end
        end else if (i_shift_en) begin
            r_hist[0] <= i_shift_char;
            for (int k = 1; k < int'(DEPTH); k++) begin
                r_hist[k] <= r_hist[k-1];
            end
        end
    end

    assign o_rd_char = (32'(i_rd_idx) < DEPTH) ? r_hist[i_rd_idx] : '0;

endmodule

// File: rtl/lz77_decoder.sv
// LZ77 token decoder: copies match_len chars from history, then emits the literal.
// One output character per clock; '$' ends decoding until reset.
module lz77_decoder
    import lz77_pkg::*;
(
    input logic           clk,
    input logic           reset,
    lz77_decoder_if.slave bus
);

    dec_state_e        r_state, w_state_nxt;
    logic [OFF_W-1:0]  r_off, w_off_nxt;
    logic [LEN_W-1:0]  r_len_cnt, w_len_nxt;
    logic [CHAR_W-1:0] r_char, w_char_nxt;
    logic              r_err, w_err_nxt;
    logic              r_out_valid, r_finish;
    logic [CHAR_W-1:0] r_out_char;
    logic [CNT_W-1:0]  r_hist_cnt, w_cnt_eff;

    logic              w_ready, w_accept, w_illegal, w_emit;
    logic [CHAR_W-1:0] w_emit_char, w_hist_rd;

    assign w_emit      = (r_state == COPY) || (r_state == LIT);
    assign w_emit_char = (r_state == COPY) ? w_hist_rd : r_char;

    // Count includes the char shifted in on this edge, so a back-to-back token
    // may reference the literal that is being emitted alongside its accept.
    assign w_cnt_eff = (w_emit && (r_hist_cnt != CNT_W'(SEARCH_DEPTH))) ?
                       r_hist_cnt + 1'b1 : r_hist_cnt;

    assign w_illegal = (bus.match_len != '0) &&
                       ((bus.offset >= OFF_W'(SEARCH_DEPTH)) || (bus.offset >= w_cnt_eff));

    always_comb begin
        w_ready = 1'b0;
        unique case (r_state)
            IDLE:    w_ready = 1'b1;
            LIT:     w_ready = (r_char != TERM_CHAR);
            default: w_ready = 1'b0;
        endcase
    end

    assign w_accept = bus.code_valid && w_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_off_nxt   = r_off;
        w_len_nxt   = r_len_cnt;
        w_char_nxt  = r_char;
        w_err_nxt   = r_err;
        unique case (r_state)
            IDLE: ;
            COPY: begin
                w_len_nxt = r_len_cnt - 1'b1;
                if (r_len_cnt == LEN_W'(1)) begin
                    w_state_nxt = LIT;
                end
            end
            LIT: begin
                if (r_char == TERM_CHAR) begin
                    w_state_nxt = DONE;
                end else if (!w_accept) begin
                    w_state_nxt = IDLE;
                end
            end
            DONE: ;
        endcase
        // Token load, shared by IDLE and back-to-back LIT
        if (w_accept) begin
            w_off_nxt  = bus.offset;
            w_len_nxt  = bus.match_len;
            w_char_nxt = bus.char_nxt;
            if (w_illegal) begin
                w_err_nxt   = 1'b1;
                w_state_nxt = LIT;
            end else begin
                w_state_nxt = (bus.match_len != '0) ? COPY : LIT;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_off       <= '0;
            r_len_cnt   <= '0;
            r_char      <= '0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_char  <= '0;
            r_finish    <= 1'b0;
            r_hist_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_off       <= w_off_nxt;
            r_len_cnt   <= w_len_nxt;
            r_char      <= w_char_nxt;
            r_err       <= w_err_nxt;
            r_out_valid <= w_emit;
            r_finish    <= r_finish || (r_state == DONE);
            r_hist_cnt  <= w_cnt_eff;
            if (w_emit) begin
                r_out_char <= w_emit_char;
            end
        end
    end

    lz77_hist_buf #(
        .DEPTH (SEARCH_DEPTH)
    ) u_hist_buf (
        .clk          (clk),
        .reset        (reset),
        .i_shift_en   (w_emit),
        .i_shift_char (w_emit_char),
        .i_rd_idx     (r_off),
        .o_rd_char    (w_hist_rd)
    );

    assign bus.code_ready = w_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_char   = r_out_char;
    assign bus.finish     = r_finish;
    assign bus.err        = r_err;

endmodule

// File: tb/tb_lz77_decoder.sv
// Bench for lz77_decoder: directed scenarios plus random token streams,
// checked against a token-level history model and expected-character queue.
module tb_lz77_decoder;
    import lz77_pkg::*;

    logic clk;
    logic reset;

    lz77_decoder_if bus ();

    lz77_decoder u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    logic [7:0] exp_q [$];
    logic [7:0] m_hist [$];
    int         m_cnt;
    logic       m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_hist.delete();
        m_cnt = 0;
        m_err = 1'b0;
    endtask

    task automatic model_push(input logic [7:0] c);
        m_hist.push_front(c);
        exp_q.push_back(c);
        if (m_cnt < int'(SEARCH_DEPTH)) m_cnt++;
    endtask

    // Expected characters of one token from the decoding rules
    task automatic model_token(input int off, input int len, input logic [7:0] ch);
        int len_eff;
        len_eff = len;
        if (len != 0 && (off >= int'(SEARCH_DEPTH) || off >= m_cnt)) begin
            m_err   = 1'b1;
            len_eff = 0;
        end
        for (int i = 0; i < len_eff; i++) model_push(m_hist[off]);
        model_push(ch);
    endtask

    always @(negedge clk) begin
        if (!reset && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("extra_char", {24'h0, bus.out_char}, 32'hffff_ffff);
            end else begin
                check("out_char", {24'h0, bus.out_char}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    // Called just after a negedge; returns just after the negedge following the accept edge
    task automatic send(input int off, input int len, input logic [7:0] ch);
        int waited;
        bus.code_valid = 1'b1;
        bus.offset     = off[3:0];
        bus.match_len  = len[2:0];
        bus.char_nxt   = ch;
        waited = 0;
        while (!bus.code_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) begin
            check("ready_timeout", 32'd0, 32'd1);
        end else begin
            model_token(off, len, ch);
            @(negedge clk);
        end
        bus.code_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
        check("rst_out_char", {24'h0, bus.out_char}, 32'd0);
        check("rst_finish", {31'h0, bus.finish}, 32'd0);
        check("rst_err", {31'h0, bus.err}, 32'd0);
        check("rst_ready", {31'h0, bus.code_ready}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        int off, len, tot;
        clk            = 1'b0;
        reset          = 1'b1;
        n_checks       = 0;
        n_errors       = 0;
        bus.code_valid = 1'b0;
        bus.offset     = '0;
        bus.match_len  = '0;
        bus.char_nxt   = '0;
        model_clear();

        // Back-to-back overlapping copy: a a a a b
        do_reset();
        send(0, 0, "a");
        send(0, 3, "b");
        for (int i = 0; i < 5; i++) begin
            check("b2b_valid", {31'h0, bus.out_valid}, 32'd1);
            if (i < 3) check("copy_ready", {31'h0, bus.code_ready}, 32'd0);
            @(negedge clk);
        end
        drain();

        // Offset-2 repeated copy: a b c a b c x
        do_reset();
        send(0, 0, "a");
        send(0, 0, "b");
        send(0, 0, "c");
        send(2, 6, "x");
        drain();
        check("ex2_err", {31'h0, bus.err}, 32'd0);

        // Terminator
        do_reset();
        send(0, 0, "a");
        send(0, 0, "b");
        send(0, 0, 8'h24);
        n = 0;
        while (!(bus.out_valid && bus.out_char == 8'h24) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("term_seen", {31'h0, bus.out_valid}, 32'd1);
        check("term_finish_early", {31'h0, bus.finish}, 32'd0);
        @(negedge clk);
        check("term_finish", {31'h0, bus.finish}, 32'd1);
        check("term_valid_low", {31'h0, bus.out_valid}, 32'd0);
        check("term_ready_low", {31'h0, bus.code_ready}, 32'd0);
        bus.code_valid = 1'b1;
        bus.match_len  = '0;
        bus.char_nxt   = "w";
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("done_ready", {31'h0, bus.code_ready}, 32'd0);
            check("done_valid", {31'h0, bus.out_valid}, 32'd0);
        end
        bus.code_valid = 1'b0;
        check("done_finish", {31'h0, bus.finish}, 32'd1);

        // Illegal offset skips the copy and latches err
        do_reset();
        send(0, 0, "a");
        send(0, 0, "b");
        send(5, 2, "z");
        drain();
        check("illegal_err", {31'h0, bus.err}, 32'd1);
        send(1, 1, "y");
        drain();
        check("err_sticky", {31'h0, bus.err}, 32'd1);

        // Literal tokens with a one-cycle gap between them
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send(0, 0, 8'($urandom_range(97, 122)));
            check("gap_valid_low", {31'h0, bus.out_valid}, 32'd0);
            @(negedge clk);
        end
        drain();

        // Reset in the middle of a long copy
        do_reset();
        send(0, 0, "a");
        send(0, 0, "b");
        send(1, 7, "q");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_valid", {31'h0, bus.out_valid}, 32'd0);
        check("midrst_char", {24'h0, bus.out_char}, 32'd0);
        check("midrst_err", {31'h0, bus.err}, 32'd0);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send(0, 0, "k");
        drain();
        check("midrst_err_after", {31'h0, bus.err}, 32'd0);

        // Random token streams against the model
        for (int run = 0; run < 3; run++) begin
            do_reset();
            tot = 0;
            for (int t = 0; t < 40; t++) begin
                len = 0;
                off = int'($urandom_range(0, 15));
                if (tot > 0 && $urandom_range(0, 3) != 0) begin
                    len = int'($urandom_range(1, 7));
                    if ($urandom_range(0, 9) == 0) off = int'($urandom_range(9, 15));
                    else off = int'($urandom_range(0, ((tot < 9) ? tot : 9) - 1));
                end
                send(off, len, 8'($urandom_range(97, 122)));
                tot = m_cnt;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            drain();
            check("rand_err", {31'h0, bus.err}, {31'h0, m_err});
            check("rand_finish", {31'h0, bus.finish}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
